// File: rtl/masked_chi_iter.sv
// Two-share masked Keccak-style chi on a W-bit row, one masked AND per clock.
// Cross-share terms are always registered before they meet the other share.
module masked_chi_iter #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] share0_in,
    input  logic [W-1:0] share1_in,
    input  logic         rand_i,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] share0_out,
    output logic [W-1:0] share1_out,
    output logic         busy,
    output logic [1:0]   dbg_state_o
);

    generate
        if ((W < 3) || (W > 25) || ((W % 2) == 0)) begin : g_bad_w
            $error("masked_chi_iter: W must be odd and within 3..25");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        COMP = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int KW = $clog2(W + 1);
    localparam logic [KW-1:0] K_LAST = KW'(W);

    state_e        state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic [W-1:0]  x0_q, x0_d;
    logic [W-1:0]  x1_q, x1_d;
    logic [W-1:0]  y0_q, y0_d;
    logic [W-1:0]  y1_q, y1_d;
    logic          r0_q, r0_d;
    logic          r1_q, r1_d;

    // ia/ib: operand bits of the AND started this step; pa/ia and ip: bit being finished.
    int   ia, ib, pa, ip;
    logic a0, a1, b0, b1;
    logic pa0, pa1, pb0, pb1, xp0, xp1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            k_q     <= '0;
            x0_q    <= '0;
            x1_q    <= '0;
            y0_q    <= '0;
            y1_q    <= '0;
            r0_q    <= 1'b0;
            r1_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            x0_q    <= x0_d;
            x1_q    <= x1_d;
            y0_q    <= y0_d;
            y1_q    <= y1_d;
            r0_q    <= r0_d;
            r1_q    <= r1_d;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        x0_d    = x0_q;
        x1_d    = x1_q;
        y0_d    = y0_q;
        y1_d    = y1_q;
        r0_d    = r0_q;
        r1_d    = r1_q;

        ia = int'(k_q) + 1;
        if (ia >= W) ia = ia - W;
        ib = ia + 1;
        if (ib >= W) ib = ib - W;
        pa = int'(k_q);
        if (pa >= W) pa = pa - W;
        ip = int'(k_q) - 1;
        if (ip < 0) ip = 0;

        a0 = 1'b0; a1 = 1'b0; b0 = 1'b0; b1 = 1'b0;
        pa0 = 1'b0; pa1 = 1'b0; pb0 = 1'b0; pb1 = 1'b0;
        xp0 = 1'b0; xp1 = 1'b0;
        for (int j = 0; j < W; j++) begin
            if (j == ia) begin
                a0  = x0_q[j];
                a1  = x1_q[j];
                pb0 = x0_q[j];
                pb1 = x1_q[j];
            end
            if (j == ib) begin
                b0 = x0_q[j];
                b1 = x1_q[j];
            end
            if (j == pa) begin
                pa0 = x0_q[j];
                pa1 = x1_q[j];
            end
            if (j == ip) begin
                xp0 = x0_q[j];
                xp1 = x1_q[j];
            end
        end

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    x0_d    = share0_in;
                    x1_d    = share1_in;
                    y0_d    = '0;
                    y1_d    = '0;
                    k_d     = '0;
                    state_d = COMP;
                end
            end
            COMP: begin
                if (k_q < K_LAST) begin
                    r0_d = (~a0 & b1) ^ rand_i;
                    r1_d = (a1 & b0) ^ rand_i;
                end
                // Finish bit k-1 using only same-share terms plus the registered cross term.
                if (k_q != '0) begin
                    for (int j = 0; j < W; j++) begin
                        if (j == ip) begin
                            y0_d[j] = xp0 ^ (~pa0 & pb0) ^ r0_q;
                            y1_d[j] = xp1 ^ (pa1 & pb1) ^ r1_q;
                        end
                    end
                end
                if (k_q == K_LAST) begin
                    state_d = DONE;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign busy        = (state_q == COMP);
    assign share0_out  = y0_q;
    assign share1_out  = y1_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_masked_chi_iter.sv
// Bench for masked_chi_iter: W=3, W=5 and W=7 instances against an unmasked chi model.
module tb_masked_chi_iter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [2:0]  iv, ordy;
  logic [31:0] s0, s1;
  logic        rnd;
  wire  [2:0]  ir, ov, bz;
  wire  [2:0][31:0] o0, o1;
  wire  [2:0][1:0]  st;

  logic [31:0] exp_q[$];
  int checks = 0;
  int failures = 0;

  masked_chi_iter #(.W(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
    .share0_in(s0[2:0]), .share1_in(s1[2:0]), .rand_i(rnd),
    .out_valid(ov[0]), .out_ready(ordy[0]),
    .share0_out(o0[0][2:0]), .share1_out(o1[0][2:0]),
    .busy(bz[0]), .dbg_state_o(st[0])
  );
  assign o0[0][31:3] = '0;
  assign o1[0][31:3] = '0;

  masked_chi_iter #(.W(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
    .share0_in(s0[4:0]), .share1_in(s1[4:0]), .rand_i(rnd),
    .out_valid(ov[1]), .out_ready(ordy[1]),
    .share0_out(o0[1][4:0]), .share1_out(o1[1][4:0]),
    .busy(bz[1]), .dbg_state_o(st[1])
  );
  assign o0[1][31:5] = '0;
  assign o1[1][31:5] = '0;

  masked_chi_iter #(.W(7)) dut7 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
    .share0_in(s0[6:0]), .share1_in(s1[6:0]), .rand_i(rnd),
    .out_valid(ov[2]), .out_ready(ordy[2]),
    .share0_out(o0[2][6:0]), .share1_out(o1[2][6:0]),
    .busy(bz[2]), .dbg_state_o(st[2])
  );
  assign o0[2][31:7] = '0;
  assign o1[2][31:7] = '0;

  function automatic logic [31:0] chi_ref(input logic [31:0] x, input int w);
    logic [31:0] y;
    y = '0;
    for (int i = 0; i < w; i++)
      y[i] = x[i] ^ (~x[(i + 1) % w] & x[(i + 2) % w]);
    return y;
  endfunction

  // One full operation on instance d: share0 = sh, share1 = sh ^ x, result held for 'hold' cycles.
  task automatic run_op(input int d, input int w, input logic [31:0] sh, input logic [31:0] x,
                        input logic [31:0] e, input int hold);
    logic [31:0] m, y, want, h0, h1;
    int cyc;
    m = (32'd1 << w) - 32'd1;
    cyc = 0;
    while (ir[d] !== 1'b1 && cyc < 50) begin
      @(posedge clk); #1; cyc++;
    end
    checks++;
    if (ir[d] !== 1'b1) begin
      failures++;
      $display("FAIL in_ready_wait w=%0d: got %b expected 1", w, ir[d]);
      return;
    end
    s0 = sh & m;
    s1 = (sh ^ x) & m;
    iv[d] = 1'b1;
    rnd = 1'($urandom);
    exp_q.push_back(e);
    @(posedge clk); #1;
    iv[d] = 1'b0;
    checks++;
    if (bz[d] !== 1'b1) begin
      failures++;
      $display("FAIL busy_after_accept w=%0d: got %b expected 1", w, bz[d]);
    end
    cyc = 0;
    while (ov[d] !== 1'b1 && cyc < 60) begin
      rnd = 1'($urandom);
      s0 = $urandom;
      s1 = $urandom;
      @(posedge clk); #1; cyc++;
    end
    checks++;
    if (cyc != w + 1) begin
      failures++;
      $display("FAIL latency w=%0d: got %0d cycles expected %0d", w, cyc, w + 1);
    end
    if (ov[d] !== 1'b1) begin
      void'(exp_q.pop_front());
      return;
    end
    want = exp_q.pop_front();
    y = (o0[d] ^ o1[d]) & m;
    checks++;
    if (y !== want) begin
      failures++;
      $display("FAIL result w=%0d x=%h: got %h expected %h", w, x & m, y, want);
    end
    h0 = o0[d];
    h1 = o1[d];
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      checks++;
      if (ov[d] !== 1'b1 || ir[d] !== 1'b0 || o0[d] !== h0 || o1[d] !== h1) begin
        failures++;
        $display("FAIL hold cycle %0d: got ov=%b ir=%b s0=%h s1=%h expected ov=1 ir=0 s0=%h s1=%h",
                 i, ov[d], ir[d], o0[d], o1[d], h0, h1);
      end
    end
    ordy[d] = 1'b1;
    @(posedge clk); #1;
    ordy[d] = 1'b0;
    checks++;
    if (ir[d] !== 1'b1 || ov[d] !== 1'b0) begin
      failures++;
      $display("FAIL release w=%0d: got ir=%b ov=%b expected ir=1 ov=0", w, ir[d], ov[d]);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (ir[d] !== 1'b1 || ov[d] !== 1'b0 || bz[d] !== 1'b0 || o0[d] !== 32'd0 || o1[d] !== 32'd0) begin
        failures++;
        $display("FAIL reset_state dut%0d: got ir=%b ov=%b busy=%b s0=%h s1=%h expected 1 0 0 0 0",
                 d, ir[d], ov[d], bz[d], o0[d], o1[d]);
      end
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (ir[d] !== 1'b1 || ov[d] !== 1'b0 || st[d] !== 2'd0) begin
        failures++;
        $display("FAIL post_reset dut%0d: got ir=%b ov=%b st=%0d expected 1 0 0", d, ir[d], ov[d], st[d]);
      end
    end
  endtask

  task automatic test_known;
    run_op(1, 5, 32'b10110, 32'b00001, 32'b01001, 0);
  endtask

  task automatic test_random_sharings;
    for (int i = 0; i < 1000; i++) run_op(1, 5, $urandom, 32'b00110, 32'b10110, 0);
    for (int i = 0; i < 20; i++)   run_op(1, 5, $urandom, 32'b11111, 32'b11111, 0);
    for (int i = 0; i < 20; i++)   run_op(1, 5, $urandom, 32'b00000, 32'b00000, 0);
  endtask

  task automatic test_backpressure;
    logic [31:0] x;
    run_op(1, 5, $urandom, 32'b00001, 32'b01001, 10);
    x = $urandom_range(0, 31);
    run_op(1, 5, $urandom, x, chi_ref(x, 5), 10);
  endtask

  task automatic test_reset_mid;
    s0 = 32'b10110;
    s1 = 32'b10111;
    iv[1] = 1'b1;
    @(posedge clk); #1;
    iv[1] = 1'b0;
    repeat (3) begin
      rnd = 1'($urandom);
      @(posedge clk); #1;
    end
    checks++;
    if (st[1] !== 2'd1) begin
      failures++;
      $display("FAIL state_at_step3: got %0d expected 1", st[1]);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (ir[1] !== 1'b1 || ov[1] !== 1'b0 || bz[1] !== 1'b0 || o0[1] !== 32'd0 || o1[1] !== 32'd0) begin
      failures++;
      $display("FAIL reset_mid_comp: got ir=%b ov=%b busy=%b s0=%h s1=%h expected 1 0 0 0 0",
               ir[1], ov[1], bz[1], o0[1], o1[1]);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (ir[1] !== 1'b1 || ov[1] !== 1'b0) begin
      failures++;
      $display("FAIL after_mid_reset: got ir=%b ov=%b expected 1 0", ir[1], ov[1]);
    end
    run_op(1, 5, $urandom, 32'b00001, 32'b01001, 0);
  endtask

  task automatic test_exhaustive;
    for (int x = 0; x < 8; x++)   run_op(0, 3, $urandom, 32'(x), chi_ref(32'(x), 3), 0);
    for (int x = 0; x < 128; x++) run_op(2, 7, $urandom, 32'(x), chi_ref(32'(x), 7), 0);
  endtask

  // in_valid and out_ready held high; inputs change every cycle, only IDLE cycles may capture.
  task automatic test_back_to_back;
    logic [31:0] a, b, y, want;
    int last, n_out, cyc;
    last = -1;
    n_out = 0;
    ordy[1] = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (ov[1] === 1'b1) begin
        want = exp_q.size() > 0 ? exp_q.pop_front() : 32'hdead_beef;
        y = (o0[1] ^ o1[1]) & 32'h1f;
        checks++;
        if (y !== want) begin
          failures++;
          $display("FAIL b2b_result cycle %0d: got %h expected %h", c, y, want);
        end
        if (last >= 0) begin
          checks++;
          if (c - last != 8) begin
            failures++;
            $display("FAIL b2b_spacing: got %0d cycles expected 8", c - last);
          end
        end
        last = c;
        n_out++;
      end
      a = $urandom & 32'h1f;
      b = $urandom & 32'h1f;
      s0 = a;
      s1 = b;
      iv[1] = 1'b1;
      if (ir[1] === 1'b1) exp_q.push_back(chi_ref(a ^ b, 5));
      rnd = 1'($urandom);
      @(posedge clk); #1;
    end
    iv[1] = 1'b0;
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 30) begin
      if (ov[1] === 1'b1) begin
        want = exp_q.pop_front();
        y = (o0[1] ^ o1[1]) & 32'h1f;
        checks++;
        if (y !== want) begin
          failures++;
          $display("FAIL b2b_drain: got %h expected %h", y, want);
        end
      end
      rnd = 1'($urandom);
      @(posedge clk); #1;
      cyc++;
    end
    ordy[1] = 1'b0;
    checks++;
    if (n_out < 4) begin
      failures++;
      $display("FAIL b2b_count: got %0d results expected at least 4", n_out);
    end
  endtask

  initial begin
    iv = '0;
    ordy = '0;
    s0 = '0;
    s1 = '0;
    rnd = 1'b0;
    test_reset;
    test_known;
    test_random_sharings;
    test_backpressure;
    test_reset_mid;
    test_exhaustive;
    test_back_to_back;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_empty: got %0d pending expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
